// File: rtl/mod_unit_arbiter_pkg.sv
// Shared types for the two-requester modular add/sub arbiter.
// Holds the FSM encoding, the tag layout and the unit op codes.
// The default operand width is supplied here unless the build overrides DATA_SIZE_ARB.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 8
`endif

package mod_unit_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } arb_state_e;

    // Tag = {valid, requester id}
    localparam int TAG_W   = 2;
    localparam int TAG_VLD = 1;
    localparam int TAG_ID  = 0;

    localparam logic MOD_OP_ADD = 1'b0;
    localparam logic MOD_OP_SUB = 1'b1;

endpackage

// File: rtl/mod_unit_arbiter_if.sv
// Request/response/config bus of the arbiter plus its link to the shared unit.
// The slave modport is the arbiter view; the master modport is the environment view.
// Responses carry no backpressure; requests use a valid/ready handshake.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 8
`endif

interface mod_unit_arbiter_if #(parameter int W = `DATA_SIZE_ARB) ();
    logic         cfg_valid;
    logic [W-1:0] cfg_q;
    logic         cfg_ready;

    logic         req0_valid, req0_ready, req0_sel;
    logic [W-1:0] req0_a, req0_b;
    logic         req1_valid, req1_ready, req1_sel;
    logic [W-1:0] req1_a, req1_b;

    logic         rsp0_valid, rsp1_valid;
    logic [W-1:0] rsp0_data, rsp1_data;

    logic         unit_sel;
    logic [W-1:0] unit_q, unit_in0, unit_in1, unit_out;
    logic         busy;

    modport slave (
        input  cfg_valid, cfg_q, req0_valid, req0_sel, req0_a, req0_b,
               req1_valid, req1_sel, req1_a, req1_b, unit_out,
        output cfg_ready, req0_ready, req1_ready, rsp0_valid, rsp0_data,
               rsp1_valid, rsp1_data, unit_sel, unit_q, unit_in0, unit_in1, busy
    );

    modport master (
        output cfg_valid, cfg_q, req0_valid, req0_sel, req0_a, req0_b,
               req1_valid, req1_sel, req1_a, req1_b, unit_out,
        input  cfg_ready, req0_ready, req1_ready, rsp0_valid, rsp0_data,
               rsp1_valid, rsp1_data, unit_sel, unit_q, unit_in0, unit_in1, busy
    );
endinterface

// File: rtl/mod_unit_arbiter_rr_pick.sv
// Two-way round-robin chooser; purely combinational, zero latency.
// last_grant=1 means requester 1 won last, so requester 0 wins a tie.
module mod_rr_pick (
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    input  logic enable,
    output logic grant0,
    output logic grant1
);
    assign grant0 = enable & valid0 & (~valid1 | last_grant);
    assign grant1 = enable & valid1 & (~valid0 | ~last_grant);
endmodule

// File: rtl/mod_unit_arbiter.sv
// Round-robin sharing of one modular add/sub unit between two requesters, with safe modulus reload.
// Latency MOD_LAT+1 edges accept->rsp, one op per cycle; rsp has no backpressure, req stalls only during reload.
// Optional perf counters (grant0/1, conflict) are built when MODARB_PERF_CNT_EN is defined.
module mod_unit_arbiter
    import mod_unit_arbiter_pkg::*;
#(
    parameter int W       = `DATA_SIZE_ARB,
    parameter int MOD_LAT = 1,
    parameter int Q_RESET = 251
) (
    input  logic clk,
    input  logic reset,
    mod_unit_arbiter_if.slave bus
`ifdef MODARB_PERF_CNT_EN
    ,
    output logic [15:0] grant0_cnt,
    output logic [15:0] grant1_cnt,
    output logic [15:0] conflict_cnt
`endif
);

    arb_state_e       state_q;
    logic             cfg_ready_q;
    logic [W-1:0]     q_q;
    logic             last_grant_q;
    logic             unit_sel_q;
    logic [W-1:0]     unit_in0_q, unit_in1_q;
    logic [TAG_W-1:0] tag_q [0:MOD_LAT];
    logic             rsp0_vld_q, rsp1_vld_q;
    logic [W-1:0]     rsp0_dat_q, rsp1_dat_q;

    logic pick_en, grant0, grant1, accept, busy_w;

    assign pick_en = (state_q == ARB) && !bus.cfg_valid;
    assign accept  = grant0 | grant1;

    mod_rr_pick u_pick (
        .valid0     (bus.req0_valid),
        .valid1     (bus.req1_valid),
        .last_grant (last_grant_q),
        .enable     (pick_en),
        .grant0     (grant0),
        .grant1     (grant1)
    );

    always_comb begin
        busy_w = 1'b0;
        for (int i = 0; i <= MOD_LAT; i++) busy_w = busy_w | tag_q[i][TAG_VLD];
    end

    // Reload waits in DRAIN until every tagged op has left the pipe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ARB;
            cfg_ready_q <= 1'b0;
            q_q         <= W'(Q_RESET);
        end else begin
            cfg_ready_q <= 1'b0;
            case (state_q)
                ARB:   if (bus.cfg_valid) state_q <= DRAIN;
                DRAIN: if (!busy_w) begin
                    state_q     <= LOAD;
                    cfg_ready_q <= 1'b1;
                end
                LOAD: begin
                    q_q     <= bus.cfg_q;
                    state_q <= ARB;
                end
                default: state_q <= ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            unit_sel_q   <= MOD_OP_ADD;
            unit_in0_q   <= '0;
            unit_in1_q   <= '0;
        end else if (accept) begin
            last_grant_q <= grant1;
            unit_sel_q   <= grant1 ? bus.req1_sel : bus.req0_sel;
            unit_in0_q   <= grant1 ? bus.req1_a   : bus.req0_a;
            unit_in1_q   <= grant1 ? bus.req1_b   : bus.req0_b;
        end
    end

    // The last tag stage lines up with unit_out one edge before capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i <= MOD_LAT; i++) tag_q[i] <= '0;
            rsp0_vld_q <= 1'b0;
            rsp1_vld_q <= 1'b0;
            rsp0_dat_q <= '0;
            rsp1_dat_q <= '0;
        end else begin
            tag_q[0] <= {accept, grant1};
            for (int i = 1; i <= MOD_LAT; i++) tag_q[i] <= tag_q[i-1];
            rsp0_vld_q <= tag_q[MOD_LAT][TAG_VLD] && !tag_q[MOD_LAT][TAG_ID];
            rsp1_vld_q <= tag_q[MOD_LAT][TAG_VLD] &&  tag_q[MOD_LAT][TAG_ID];
            if (tag_q[MOD_LAT][TAG_VLD] && !tag_q[MOD_LAT][TAG_ID]) rsp0_dat_q <= bus.unit_out;
            if (tag_q[MOD_LAT][TAG_VLD] &&  tag_q[MOD_LAT][TAG_ID]) rsp1_dat_q <= bus.unit_out;
        end
    end

    assign bus.req0_ready = grant0;
    assign bus.req1_ready = grant1;
    assign bus.cfg_ready  = cfg_ready_q;
    assign bus.unit_sel   = unit_sel_q;
    assign bus.unit_q     = q_q;
    assign bus.unit_in0   = unit_in0_q;
    assign bus.unit_in1   = unit_in1_q;
    assign bus.rsp0_valid = rsp0_vld_q;
    assign bus.rsp1_valid = rsp1_vld_q;
    assign bus.rsp0_data  = rsp0_dat_q;
    assign bus.rsp1_data  = rsp1_dat_q;
    assign bus.busy       = busy_w;

`ifdef MODARB_PERF_CNT_EN
    logic [15:0] grant0_cnt_q, grant1_cnt_q, conflict_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            grant0_cnt_q   <= '0;
            grant1_cnt_q   <= '0;
            conflict_cnt_q <= '0;
        end else begin
            if (grant0 && grant0_cnt_q != 16'hFFFF) grant0_cnt_q <= grant0_cnt_q + 16'd1;
            if (grant1 && grant1_cnt_q != 16'hFFFF) grant1_cnt_q <= grant1_cnt_q + 16'd1;
            if (state_q == ARB && bus.req0_valid && bus.req1_valid)
                conflict_cnt_q <= conflict_cnt_q + 16'd1;
        end
    end

    assign grant0_cnt   = grant0_cnt_q;
    assign grant1_cnt   = grant1_cnt_q;
    assign conflict_cnt = conflict_cnt_q;
`endif

endmodule

// File: tb/tb_mod_unit_arbiter.sv
// Self-checking bench for mod_unit_arbiter with a behavioural model of the shared unit.
// Directed corner sequences, an arbitration vector table and a randomized scoreboard run.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 8
`endif

module tb_mod_unit_arbiter;
    import mod_unit_arbiter_pkg::*;

    localparam int W       = `DATA_SIZE_ARB;
    localparam int MOD_LAT = 1;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    mod_unit_arbiter_if #(.W(W)) bus ();

`ifdef MODARB_PERF_CNT_EN
    logic [15:0] g0_cnt, g1_cnt, c_cnt;
`endif

    mod_unit_arbiter #(.W(W), .MOD_LAT(MOD_LAT), .Q_RESET(251)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef MODARB_PERF_CNT_EN
        ,
        .grant0_cnt   (g0_cnt),
        .grant1_cnt   (g1_cnt),
        .conflict_cnt (c_cnt)
`endif
    );

    // Shared unit: registered modular add/sub, MOD_LAT edges deep.
    logic [W-1:0] upipe [MOD_LAT];

    function automatic logic [W-1:0] unit_f(input logic sel, input logic [W-1:0] a,
                                            input logic [W-1:0] b, input logic [W-1:0] q);
        logic [W:0] s;
        if (sel == MOD_OP_SUB) begin
            s = {1'b0, a} - {1'b0, b};
            if (a < b) s = s + {1'b0, q};
        end else begin
            s = {1'b0, a} + {1'b0, b};
            if (s >= {1'b0, q}) s = s - {1'b0, q};
        end
        return s[W-1:0];
    endfunction

    always @(posedge clk) begin
        upipe[0] <= unit_f(bus.unit_sel, bus.unit_in0, bus.unit_in1, bus.unit_q);
        for (int i = 1; i < MOD_LAT; i++) upipe[i] <= upipe[i-1];
    end
    assign bus.unit_out = upipe[MOD_LAT-1];

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    typedef struct { int due; logic id; int val; } pend_t;
    pend_t pend[$];

    typedef struct { logic v0; logic v1; logic cfg; logic r0; logic r1; } arb_vec_t;
    arb_vec_t vt [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        bus.cfg_valid  = 1'b0;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic set0(input logic v, input logic s, input int a, input int b);
        bus.req0_valid = v; bus.req0_sel = s;
        bus.req0_a = a[W-1:0]; bus.req0_b = b[W-1:0];
    endtask

    task automatic set1(input logic v, input logic s, input int a, input int b);
        bus.req1_valid = v; bus.req1_sel = s;
        bus.req1_a = a[W-1:0]; bus.req1_b = b[W-1:0];
    endtask

    task automatic do_reset();
        reset = 1'b0;
        idle();
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Scoreboard step: one due result per cycle at most, since one accept per cycle.
    task automatic check_rsp();
        logic e0, e1;
        int   ev;
        e0 = 1'b0; e1 = 1'b0; ev = 0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            ev = pend[0].val;
            if (pend[0].id) e1 = 1'b1; else e0 = 1'b1;
            void'(pend.pop_front());
        end
        chk("rnd_rsp0_vld", bus.rsp0_valid, e0);
        chk("rnd_rsp1_vld", bus.rsp1_valid, e1);
        if (e0) chk("rnd_rsp0_dat", bus.rsp0_data, ev);
        if (e1) chk("rnd_rsp1_dat", bus.rsp1_data, ev);
        chk("rnd_busy", bus.busy, pend.size() != 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: reached cycle %0d without finishing, required finish", cyc);
        $display("%0d/%0d checks passed", n_pass, n_tot + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        logic v0, v1;
        int   w, a0, b0, a1, b1, mq, mlast;
        logic s0, s1;

        bus.cfg_q = '0;
        set0(1'b0, 1'b0, 0, 0);
        set1(1'b0, 1'b0, 0, 0);
        do_reset();

        chk("rst_busy", bus.busy, 0);
        chk("rst_unit_q", bus.unit_q, 251);
        chk("rst_cfg_ready", bus.cfg_ready, 0);
        chk("rst_rsp0_vld", bus.rsp0_valid, 0);
        chk("rst_rsp1_vld", bus.rsp1_valid, 0);
        chk("rst_unit_sel", bus.unit_sel, 0);
        chk("rst_unit_in0", bus.unit_in0, 0);

        // Arbitration table from the reset state (last_grant = requester 1).
        vt[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[1] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        vt[2] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        vt[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            bus.req0_valid = vt[i].v0;
            bus.req1_valid = vt[i].v1;
            bus.cfg_valid  = vt[i].cfg;
            #1;
            chk("tbl_ready0", bus.req0_ready, vt[i].r0);
            chk("tbl_ready1", bus.req1_ready, vt[i].r1);
        end
        idle();

        // Single add, latency two edges.
        set0(1'b1, MOD_OP_ADD, 200, 100);
        #1 chk("add_ready0", bus.req0_ready, 1);
        tick();
        idle();
        chk("add_busy", bus.busy, 1);
        chk("add_rsp0_e0", bus.rsp0_valid, 0);
        tick();
        chk("add_rsp0_e1", bus.rsp0_valid, 0);
        tick();
        chk("add_rsp0_e2", bus.rsp0_valid, 1);
        chk("add_rsp0_dat", bus.rsp0_data, 49);
        chk("add_rsp1_e2", bus.rsp1_valid, 0);
        tick();
        chk("add_rsp0_e3", bus.rsp0_valid, 0);
        chk("add_busy_end", bus.busy, 0);

        // Back-to-back alternation with both requesters valid.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            set0(i < 4, MOD_OP_SUB, 10, 20);
            set1(i < 4, MOD_OP_ADD, 5, 6);
            #1;
            if (i < 4) begin
                chk("alt_ready0", bus.req0_ready, (i % 2) == 0);
                chk("alt_ready1", bus.req1_ready, (i % 2) == 1);
            end
            tick();
            if (i >= 2) begin
                w = (i - 2) % 2;
                chk("alt_rsp0_vld", bus.rsp0_valid, w == 0);
                chk("alt_rsp1_vld", bus.rsp1_valid, w == 1);
                if (w == 0) chk("alt_rsp0_dat", bus.rsp0_data, 241);
                else        chk("alt_rsp1_dat", bus.rsp1_data, 11);
            end
        end
        idle();

        // Modulus reload with two operations in flight.
        set0(1'b1, MOD_OP_ADD, 3, 4);
        #1 chk("cfg_pre_ready0", bus.req0_ready, 1);
        tick();
        set0(1'b0, MOD_OP_ADD, 0, 0);
        set1(1'b1, MOD_OP_SUB, 1, 2);
        #1 chk("cfg_pre_ready1", bus.req1_ready, 1);
        tick();
        set1(1'b0, MOD_OP_ADD, 0, 0);
        set0(1'b1, MOD_OP_ADD, 10, 9);
        bus.cfg_valid = 1'b1;
        bus.cfg_q     = 8'd17;
        seen = 1'b0;
        for (int k = 0; k < 12 && !seen; k++) begin
            #1 chk("cfg_blk_ready0", bus.req0_ready, 0);
            tick();
            if (bus.cfg_ready) begin
                seen = 1'b1;
                chk("cfg_busy_at_load", bus.busy, 0);
            end
        end
        chk("cfg_ready_seen", seen, 1);
        tick();
        bus.cfg_valid = 1'b0;
        chk("cfg_ready_once", bus.cfg_ready, 0);
        chk("cfg_unit_q", bus.unit_q, 17);
        #1 chk("cfg_post_ready0", bus.req0_ready, 1);
        tick();
        idle();
        tick();
        tick();
        chk("cfg_rsp0_vld", bus.rsp0_valid, 1);
        chk("cfg_rsp0_dat", bus.rsp0_data, 2);

        // Reset while an op is in flight discards it.
        set0(1'b1, MOD_OP_ADD, 1, 1);
        tick();
        idle();
        tick();
        reset = 1'b0;
        #1;
        chk("rstf_busy", bus.busy, 0);
        chk("rstf_unit_q", bus.unit_q, 251);
        chk("rstf_rsp0", bus.rsp0_valid, 0);
        tick();
        tick();
        reset = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rstf_no_rsp0", bus.rsp0_valid, 0);
        end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("rstf_first_r0", bus.req0_ready, 1);
        chk("rstf_first_r1", bus.req1_ready, 0);
        idle();

`ifdef MODARB_PERF_CNT_EN
        do_reset();
        set0(1'b1, MOD_OP_ADD, 1, 2);
        set1(1'b1, MOD_OP_SUB, 3, 1);
        for (int k = 0; k < 10; k++) tick();
        idle();
        chk("perf_g0", g0_cnt, 5);
        chk("perf_g1", g1_cnt, 5);
        chk("perf_conflict", c_cnt, 10);
        tick();
        tick();
`endif

        // Reload while idle: DRAIN one cycle, LOAD one cycle.
        bus.cfg_valid = 1'b1;
        bus.cfg_q     = 8'd13;
        set0(1'b1, MOD_OP_ADD, 0, 0);
        #1 chk("idle_cfg_r0_arb", bus.req0_ready, 0);
        tick();
        chk("idle_cfg_rdy_drain", bus.cfg_ready, 0);
        chk("idle_cfg_r0_drain", bus.req0_ready, 0);
        tick();
        chk("idle_cfg_rdy_load", bus.cfg_ready, 1);
        chk("idle_cfg_r0_load", bus.req0_ready, 0);
        tick();
        bus.cfg_valid = 1'b0;
        idle();
        chk("idle_cfg_rdy_after", bus.cfg_ready, 0);
        chk("idle_cfg_unit_q", bus.unit_q, 13);

        // Randomized traffic against the scoreboard; requester 1 won last in every build.
        mq    = 13;
        mlast = 1;
        for (int n = 0; n < 400; n++) begin
            v0 = ($urandom % 4) != 0;
            v1 = ($urandom % 4) != 0;
            s0 = 1'($urandom % 2);
            s1 = 1'($urandom % 2);
            a0 = $urandom_range(mq - 1, 0); b0 = $urandom_range(mq - 1, 0);
            a1 = $urandom_range(mq - 1, 0); b1 = $urandom_range(mq - 1, 0);
            set0(v0, s0, a0, b0);
            set1(v1, s1, a1, b1);
            #1;
            if (v0 && v1) w = (mlast == 1) ? 0 : 1;
            else if (v0)  w = 0;
            else if (v1)  w = 1;
            else          w = -1;
            chk("rnd_ready0", bus.req0_ready, w == 0);
            chk("rnd_ready1", bus.req1_ready, w == 1);
            if (w == 0) pend.push_back('{cyc + MOD_LAT + 2, 1'b0, s0 ? (a0 - b0 + mq) % mq : (a0 + b0) % mq});
            if (w == 1) pend.push_back('{cyc + MOD_LAT + 2, 1'b1, s1 ? (a1 - b1 + mq) % mq : (a1 + b1) % mq});
            if (w >= 0) mlast = w;
            tick();
            check_rsp();
        end
        idle();
        for (int k = 0; k < MOD_LAT + 3; k++) begin
            tick();
            check_rsp();
        end
        chk("rnd_drained", pend.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/mod_unit_arbiter.md
Name: mod_unit_arbiter

Overview:
- Shares one external modular add/sub unit (combined add/sub, registered output) between two requesters, e.g. two butterfly lanes of the NTT datapath.
- Round-robin arbitration on valid/ready request ports; results are routed back by tag.
- Owns the modulus register and reconfigures it safely: it drains all in-flight operations before latching a new modulus.
- The unit sits next to this block; the arbiter drives its sel/q/in0/in1 and samples its out.

Parameters:
- W, `DATA_SIZE_ARB, operand/result width.
- MOD_LAT, 1, latency of the shared unit in clock edges from its inputs to its out (>=1).
- Q_RESET, 251, reset value of the modulus register.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  modulus-update request; held until cfg_ready.
- cfg_q  in  W  new modulus.
- cfg_ready  out  1  one-cycle pulse: modulus latched this edge.
- req0_valid / req1_valid  in  1  operation request.
- req0_ready / req1_ready  out  1  request accepted when valid&ready at the edge.
- req0_sel / req1_sel  in  1  0 = add, 1 = sub (in0-in1).
- req0_a, req0_b / req1_a, req1_b  in  W  operands, already reduced to < q.
- rsp0_valid / rsp1_valid  out  1  one-cycle result strobe; no backpressure.
- rsp0_data / rsp1_data  out  W  result.
- unit_sel  out  1  to the shared unit.
- unit_q  out  W  to the shared unit.
- unit_in0, unit_in1  out  W  to the shared unit.
- unit_out  in  W  from the shared unit.
- busy  out  1  any operation in flight.

Behaviour:
- Reset (reset=0, async): state=ARB, q_reg=Q_RESET, last_grant=1 (so req0 wins first).
  - Cleared to 0: all tag/valid pipeline stages, unit_sel/unit_in0/unit_in1, rsp*, cfg_ready.
  - In-flight operations are discarded; no rsp fires after reset release for them.
- reqN_ready is combinational from state, last_grant and the valid inputs.
- State ARB:
  - Only one valid: grant it.
  - Both valid: grant the requester that is not last_grant.
  - last_grant updates only on an accepting edge.
  - cfg_valid=1 in ARB: no grant that cycle (both ready=0); go to DRAIN.
- State DRAIN:
  - Both ready=0.
  - When the pipeline is empty (busy=0): go to LOAD.
  - If busy=0 already when cfg_valid is first seen, DRAIN lasts exactly one cycle.
- State LOAD:
  - cfg_ready=1 for one cycle; q_reg<=cfg_q at that edge; go to ARB.
  - Requests are not granted in LOAD.
- Issue (accepting edge E):
  - unit_sel/in0/in1 are registered from the winner at edge E.
  - A tag {valid, id} is pushed into a MOD_LAT+1 deep shift register.
- Result capture:
  - At edge E+MOD_LAT+1: rsp<id>_data<=unit_out and rsp<id>_valid=1 for one cycle.
  - The other rsp*_valid=0; rsp*_data holds its last value.
- Latency: MOD_LAT+1 edges from accept to rsp; throughput is one operation per cycle, back-to-back.
- busy is the OR of all tag valid bits. unit_q=q_reg.
- Results from both requesters interleave in grant order; no reordering.
- cfg_valid deasserted before cfg_ready is illegal; the behaviour is undefined.

Optional Feature:
- Macro MODARB_PERF_CNT_EN. When defined, add outputs:
  - grant0_cnt, grant1_cnt (16-bit): count accepts, saturating at 0xFFFF.
  - conflict_cnt (16-bit): counts cycles with both valid in ARB.
  - All cleared by reset.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package/defines file holds:
  - the state encodings ARB=2'd0, DRAIN=2'd1, LOAD=2'd2;
  - the tag width (1 valid + 1 id);
  - the sel codes MOD_OP_ADD=0, MOD_OP_SUB=1.
- One natural sub-module: mod_rr_pick. A 2-way round-robin chooser with inputs valid0, valid1, last_grant, enable and outputs grant0, grant1. It is purely combinational; last_grant is kept in the parent.

Test Plan:
- q=251, req0 add a=200 b=100, MOD_LAT=1 -> rsp0_valid exactly 2 edges after accept, rsp0_data=49; rsp1_valid stays 0.
- Both valid continuously: req0 sub 10,20 and req1 add 5,6 -> grants alternate 0,1,0,1; rsp0_data=241, rsp1_data=11; one result per cycle.
- cfg_valid with cfg_q=17 while 2 operations are in flight -> ready=0 until busy=0, cfg_ready pulses once, then unit_q=17; next add 10+9 -> 2.
- cfg_valid while idle -> DRAIN 1 cycle, LOAD 1 cycle, cfg_ready 2 cycles after cfg_valid rises.
- reset asserted one cycle after an accept -> rsp0_valid never pulses, busy=0, unit_q=251, first post-reset grant goes to req0.
- Under MODARB_PERF_CNT_EN: 10 cycles of both-valid -> grant0_cnt=5, grant1_cnt=5, conflict_cnt=10.
